// File: rtl/mel_pkg.sv
// Shared sample definitions for the mel front end.
// Used by audio_framer and power_spectrum.
package mel_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_ring_ram.sv
// N-word sample store: one synchronous write port,
// one asynchronous read port (distributed RAM).
module sample_ring_ram
  import mel_pkg::*;
#(
  parameter int N  = 512,
  parameter int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  sample_t mem [N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/audio_framer.sv
// Cuts a sample stream into N-sample frames that
// start HOP samples apart, streamed to power_spectrum.
module audio_framer
  import mel_pkg::*;
#(
  parameter int N   = 512,
  parameter int HOP = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] in,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [SAMPLE_W-1:0] out,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last
);

  localparam int AW = $clog2(N);

  localparam logic [AW:0]   LAST_CNT = (AW+1)'(N-1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N-1);
  localparam logic [AW-1:0] HOP_A    = AW'(HOP);
  localparam logic [AW:0]   HOP_C    = (AW+1)'(HOP);

  typedef enum logic {FILL, EMIT} framer_state_t;

  framer_state_t state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [AW:0]   count_q, count_d;

  logic          we;
  logic [AW-1:0] raddr;
  sample_t       rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      base_q   <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    base_d   = base_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_d  = EMIT;
            rd_idx_d = '0;
          end
        end
      end
      EMIT: begin
        m_valid = 1'b1;
        m_last  = (rd_idx_q == LAST_IDX);
        if (m_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          // Keep the overlapping tail; only HOP slots free up.
          if (m_last) begin
            base_d  = base_q + HOP_A;
            count_d = count_q - HOP_C;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign raddr = base_q + rd_idx_q;
  assign out   = m_valid ? rdata : '0;

  sample_ring_ram #(
    .N (N),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(in),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_audio_framer.sv
// Randomized bench for audio_framer: two instances
// (512/256 overlap and 16/16 no overlap) vs a frame model.
module tb_audio_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d [2];
  logic        sv_d  [2];
  logic [15:0] din_d [2];
  logic        mr_d  [2];
  logic        sr_w  [2];
  logic        mv_w  [2];
  logic        ml_w  [2];
  logic [15:0] ot_w  [2];

  audio_framer #(.N(512), .HOP(256)) dut_a (
    .clk    (clk),
    .reset  (rst_d[0]),
    .in     (din_d[0]),
    .s_valid(sv_d[0]),
    .s_ready(sr_w[0]),
    .out    (ot_w[0]),
    .m_valid(mv_w[0]),
    .m_ready(mr_d[0]),
    .m_last (ml_w[0])
  );

  audio_framer #(.N(16), .HOP(16)) dut_b (
    .clk    (clk),
    .reset  (rst_d[1]),
    .in     (din_d[1]),
    .s_valid(sv_d[1]),
    .s_ready(sr_w[1]),
    .out    (ot_w[1]),
    .m_valid(mv_w[1]),
    .m_ready(mr_d[1]),
    .m_last (ml_w[1])
  );

  int checks   = 0;
  int failures = 0;

  int nn [2] = '{512, 16};
  int hh [2] = '{256, 16};
  int hist [2][4096];
  int acc  [2];
  int fr   [2];
  int ridx [2];
  bit hs_in [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_clear(int id);
    acc[id]  = 0;
    fr[id]   = 0;
    ridx[id] = 0;
  endtask

  // A frame f is ready once samples f*HOP .. f*HOP+N-1 exist.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int id = 0; id < 2; id++) begin
      bit ev;
      int eo;
      ev = (acc[id] >= fr[id] * hh[id] + nn[id]);
      eo = ev ? hist[id][fr[id] * hh[id] + ridx[id]] : 0;
      chk(id == 0 ? "A_m_valid" : "B_m_valid", 32'(mv_w[id]), 32'(ev));
      chk(id == 0 ? "A_s_ready" : "B_s_ready", 32'(sr_w[id]), 32'(!ev));
      chk(id == 0 ? "A_out" : "B_out", 32'(ot_w[id]), 32'(eo));
      chk(id == 0 ? "A_m_last" : "B_m_last", 32'(ml_w[id]),
          32'(ev && ridx[id] == nn[id] - 1));
      hs_in[id] = sv_d[id] && sr_w[id] && rst_d[id];
      if (rst_d[id]) begin
        if (!ev && sv_d[id]) begin
          hist[id][acc[id]] = int'(din_d[id]);
          acc[id]++;
        end
        if (ev && mr_d[id]) begin
          if (ridx[id] == nn[id] - 1) begin
            ridx[id] = 0;
            fr[id]++;
          end else begin
            ridx[id]++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic bpv(int mode, int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 5 == 1 || k % 5 == 4) ? 1'b0 : 1'b1;
      default: return ($urandom_range(0, 99) < 65);
    endcase
  endfunction

  task automatic feed(int id, int start, int n, int stall, int bp,
                      int abort_at);
    int sent = 0;
    int guard = 0;
    int k = 0;
    while (sent < n && guard < 20000) begin
      sv_d[id]  = (stall == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall);
      din_d[id] = 16'(start + sent);
      mr_d[id]  = bpv(bp, k);
      k++;
      tick();
      if (hs_in[id]) sent++;
      guard++;
    end
    sv_d[id] = 1'b0;
    chk("feed_count", 32'(sent), 32'(n));
    guard = 0;
    while (mv_w[id] === 1'b1 && guard < 5000) begin
      if (abort_at >= 0 && ridx[id] == abort_at) begin
        rst_d[id] = 1'b0;
        #1;
        chk("rst_m_valid", 32'(mv_w[id]), 0);
        chk("rst_s_ready", 32'(sr_w[id]), 1);
        chk("rst_out", 32'(ot_w[id]), 0);
        chk("rst_m_last", 32'(ml_w[id]), 0);
        mdl_clear(id);
        tick();
        tick();
        rst_d[id] = 1'b1;
        tick();
        break;
      end
      mr_d[id] = bpv(bp, k);
      k++;
      tick();
      guard++;
    end
    mr_d[id] = 1'b1;
    chk("drain_done", 32'(mv_w[id]), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_d[i] = 1'b0;
      sv_d[i]  = 1'b0;
      din_d[i] = '0;
      mr_d[i]  = 1'b1;
      mdl_clear(i);
    end
    tick();
    tick();
    tick();
    rst_d[0] = 1'b1;
    rst_d[1] = 1'b1;
    tick();

    feed(0, 0,    512, 0,  0, -1);
    feed(0, 512,  256, 0,  0, -1);
    feed(0, 768,  256, 0,  0, -1);
    feed(0, 1024, 256, 0,  1, -1);
    feed(0, 1280, 256, 30, 2, -1);
    feed(0, 1536, 256, 0,  0, 100);
    feed(0, 1000, 512, 0,  0, -1);
    feed(0, 1512, 256, 50, 2, -1);
    feed(0, $urandom_range(0, 30000), 256, 40, 1, -1);

    feed(1, 0,  16, 0,  0, -1);
    feed(1, 16, 16, 0,  0, -1);
    feed(1, 32, 16, 0,  0, -1);
    feed(1, 48, 16, 40, 1, -1);
    feed(1, $urandom_range(0, 30000), 16, 60, 2, -1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_framer.md
# audio_framer

Converts a continuous stream of 16-bit audio samples into overlapping N-sample frames for `power_spectrum`. It acts as the AXI-stream master that drives the spectrum block's `s_valid`/`s_ready`/`s_last` input. Samples are held in an N-deep ring buffer. Each frame is emitted back-to-back with `m_last` on its final sample. Consecutive frames start HOP samples apart.

## Interface
Parameters:
- `N`, 512: frame length in samples; must be a power of 2 and ≥ 4.
- `HOP`, 256: frame advance in samples; 1 ≤ HOP ≤ N.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in`  in  16  incoming audio sample (signed, passed through untouched).
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  framer can accept a sample.
- `out`  out  16  frame sample to the spectrum block.
- `m_valid`  out  1  `out` is valid.
- `m_ready`  in  1  downstream accepts `out`.
- `m_last`  out  1  marks sample N-1 of the current frame.

## Operation
- Storage is a ring buffer `mem[0:N-1]` of 16-bit words. It is not reset.
- Pointers are `wr_ptr`, `base` and `rd_idx`, each `$clog2(N)` bits. They wrap modulo N naturally.
- `count` (`$clog2(N)+1` bits) holds the number of stored samples at or after `base`.
- State `FILL`:
  - `s_ready = 1`, `m_valid = 0`.
  - On an input handshake, write `mem[wr_ptr] <= in`, then `wr_ptr++` and `count++`.
  - When the handshake makes `count == N`, go to `EMIT` with `rd_idx = 0`.
- State `EMIT`:
  - `s_ready = 0`, `m_valid = 1`.
  - `out = mem[base + rd_idx]` (asynchronous read).
  - `m_last = (rd_idx == N-1)`.
  - On an output handshake, `rd_idx++`.
  - On the handshake with `m_last = 1`: `base += HOP`, `count -= HOP`, go to `FILL`.
- With `HOP == N`, `count` returns to 0 after each frame (no overlap).
- Reading below `count` never touches a slot that is being written, because writes are blocked in `EMIT`.
- Whenever `m_valid = 0`, `out` and `m_last` are forced to 0.
- Arithmetic:
  - `base + rd_idx` and `base + HOP` are truncated to `$clog2(N)` bits (wrap-around is intended).
  - `count` never exceeds N and never goes below 0.

## Timing
- Reset values (asserted asynchronously):
  - State is `FILL`.
  - `wr_ptr`, `base`, `rd_idx` and `count` are 0.
  - `s_ready = 1`, `m_valid = 0`, `m_last = 0`, `out = 0`.
- Latency, frame start: the handshake that stores the N-th sample in cycle t gives `m_valid = 1` at t+1, with `out` showing the frame's first sample.
- Emission: one sample per cycle while `m_ready = 1`. A full frame with no stalls takes exactly N cycles.
- Backpressure: while `m_valid && !m_ready`, `out`, `m_last` and `rd_idx` hold.
- Frame end: after the `m_last` handshake in cycle t, `m_valid = 0` and `s_ready = 1` at t+1.
- The next frame is available once HOP further samples have been accepted. There are no idle cycles beyond that requirement.
- Input during `EMIT` is stalled (`s_ready = 0`). The upstream must tolerate stalls of up to N cycles plus any downstream backpressure.
- Simultaneous events: an input handshake and an output handshake never coincide, because their states are exclusive.
- Reset asserted mid-frame:
  - The partial frame is dropped and all pointers return to 0.
  - `m_valid` drops immediately.
  - The downstream must be reset together with this block; `power_spectrum` uses the same reset.

## Structure
- Shared package `mel_pkg` holds `SAMPLE_W = 16` and typedef `sample_t = logic [SAMPLE_W-1:0]`. Both this block and `power_spectrum` use it.
- `typedef enum logic {FILL, EMIT} framer_state_t` is local to this module.
- One sub-module is natural: `sample_ring_ram`, a parameterised N×16 memory with one synchronous write port and one asynchronous read port. It maps to distributed RAM.

## Test plan
- **First frame** (N=512, HOP=256): feed ramp 0..511 with `m_ready = 1`.
  - Expect `out` = 0..511 over 512 consecutive cycles.
  - Expect `m_last` only on 511.
  - `s_ready` is low for exactly 512 cycles.
- **Overlap:** continue the ramp with 512..767.
  - Second frame is 256..767, and `m_valid` rises only after sample 767 is accepted.
  - Third frame (after 768..1023) is 512..1023; this checks pointer wrap.
- **Backpressure:** drive `m_ready` with a 1-0-1-1-0 pattern during a frame.
  - `out` holds during each low cycle.
  - No sample is skipped or duplicated; 512 handshakes in total.
- **HOP = N = 16:** feed 0..47.
  - Frames are 0..15, 16..31 and 32..47.
  - `count` is 0 after each `m_last`.
- **Reset mid-frame:** assert `reset` low while `rd_idx = 100`.
  - `m_valid = 0` immediately and `s_ready = 1`.
  - After release, feed 512 samples 1000..1511; the emitted frame is exactly 1000..1511.
- **Input stalls:** toggle `s_valid` randomly while filling.
  - The frame still starts exactly one cycle after the 512th handshake.
  - No extra words are written while `s_valid = 0`.
